// File: rtl/i2s_tx_if.sv
// Sample-in / I2S-out bundle for i2s_tx: the effect stage drives the sample side,
// the serializer drives the codec side and the event flags.
interface i2s_tx_if #(
  parameter int SIG_BITS = 16
);
  logic [SIG_BITS-1:0] in;
  logic                in_valid;
  logic                mute;
  logic                bclk;
  logic                lrclk;
  logic                sdata;
  logic                frame_start;
  logic                underrun;
  logic                overrun;

  modport master (
    output in, in_valid, mute,
    input  bclk, lrclk, sdata, frame_start, underrun, overrun
  );

  modport slave (
    input  in, in_valid, mute,
    output bclk, lrclk, sdata, frame_start, underrun, overrun
  );
endinterface

// File: rtl/i2s_tx.sv
// Mono sample to free-running I2S frame serializer with a one-entry holding buffer.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified placement (MSB in slots 0 and SLOT_BITS).
module i2s_tx #(
  parameter int SIG_BITS  = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 8
) (
  input logic     clk,
  input logic     reset,
  i2s_tx_if.slave bus
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int HW         = $clog2(BCLK_HALF);
  localparam int SW         = $clog2(FRAME_BITS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [HW-1:0]       half_cnt;
  logic [SW-1:0]       slot_cnt;
  logic                bclk_q, lrclk_q, sdata_q;
  logic                frame_start_q, underrun_q, overrun_q;
  logic                hold_full;
  logic [SIG_BITS-1:0] hold_val, last_val, frame_word;

  logic                half_wrap, bclk_fall, frame_load;
  logic [SW-1:0]       slot_next, slot_pos, bit_shift;
  logic                bit_valid, tx_bit;
  logic [SIG_BITS-1:0] load_word, tx_word, shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Slot timing and the bit to launch on the coming BCLK falling edge.
  // The frame-load cycle serializes the freshly selected word so slot 0 sees it.
  always_comb begin
    half_wrap  = (state == RUN) && (half_cnt == HW'(BCLK_HALF - 1));
    bclk_fall  = half_wrap && bclk_q;
    slot_next  = (slot_cnt == SW'(FRAME_BITS - 1)) ? '0 : slot_cnt + SW'(1);
    frame_load = bclk_fall && (slot_next == '0);
    load_word  = hold_full ? hold_val : last_val;
    tx_word    = frame_load ? (bus.mute ? '0 : load_word) : frame_word;
    slot_pos   = (slot_next >= SW'(SLOT_BITS)) ? slot_next - SW'(SLOT_BITS) : slot_next;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    bit_valid  = slot_pos < SW'(SIG_BITS);
    bit_shift  = slot_pos;
`else
    bit_valid  = (slot_pos != '0) && (slot_pos <= SW'(SIG_BITS));
    bit_shift  = slot_pos - SW'(1);
`endif
    shifted    = tx_word << bit_shift;
    tx_bit     = bit_valid & shifted[SIG_BITS-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt      <= '0;
      slot_cnt      <= SW'(FRAME_BITS - 1);
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      hold_full     <= 1'b0;
      hold_val      <= '0;
      last_val      <= '0;
      frame_word    <= '0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;

      if (state == IDLE) begin
        half_cnt <= '0;
        slot_cnt <= SW'(FRAME_BITS - 1);
        bclk_q   <= 1'b0;
        lrclk_q  <= 1'b0;
        sdata_q  <= 1'b0;
      end else begin
        half_cnt <= half_wrap ? '0 : half_cnt + HW'(1);
        if (half_wrap) bclk_q <= ~bclk_q;
        if (bclk_fall) begin
          slot_cnt <= slot_next;
          lrclk_q  <= (slot_next >= SW'(SLOT_BITS));
          sdata_q  <= tx_bit;
        end
        if (frame_load) begin
          frame_word    <= bus.mute ? '0 : load_word;
          last_val      <= load_word;
          frame_start_q <= 1'b1;
          underrun_q    <= ~hold_full;
        end
      end

      // A strobe coinciding with the frame load refills the buffer just emptied.
      if (bus.in_valid) begin
        hold_val  <= bus.in;
        hold_full <= 1'b1;
        overrun_q <= hold_full && !frame_load;
      end else if (frame_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bus.bclk        = bclk_q;
  assign bus.lrclk       = lrclk_q;
  assign bus.sdata       = sdata_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-by-frame vector table plus reset and startup sequences.
module tb_i2s_tx;

  localparam int SIG_BITS  = 16;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_HALF = 2;
  localparam int FRAME     = 2 * SLOT_BITS;
  localparam int NVEC      = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  i2s_tx_if #(.SIG_BITS(SIG_BITS)) bus ();

  i2s_tx #(
    .SIG_BITS (SIG_BITS),
    .SLOT_BITS(SLOT_BITS),
    .BCLK_HALF(BCLK_HALF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s1;
    logic [15:0] v1;
    int          s2;
    logic [15:0] v2;
    bit          ld;
    logic [15:0] ldv;
    bit          mute;
    logic [15:0] exp_word;
    bit          exp_under;
    int          exp_over;
  } frame_vec_t;

  frame_vec_t  tbl [NVEC];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sd_bits, lr_bits;
  int          bclk_errs, over_cnt, fs_extra, waited;
  logic        start_under;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] expected_frame(input logic [15:0] w);
    logic [63:0] f = '0;
    for (int s = 0; s < FRAME; s++) begin
      int p = s % SLOT_BITS;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      if (p < SIG_BITS) f[s] = w[SIG_BITS-1-p];
`else
      if (p >= 1 && p <= SIG_BITS) f[s] = w[SIG_BITS-p];
`endif
    end
    return f;
  endfunction

  task automatic apply_stimulus(input logic [15:0] value);
    bus.in       = value;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) $display("[TB] FAIL frame_wait: got no frame_start, expected one within 600 cycles");
  endtask

  // Entered on the negedge showing frame_start; leaves on the next frame's first negedge.
  task automatic capture_frame(input int s1, input logic [15:0] v1, input int s2, input logic [15:0] v2,
                               input bit ld, input logic [15:0] ldv, input bit next_mute);
    sd_bits = '0; lr_bits = '0;
    bclk_errs = 0; over_cnt = 0; fs_extra = 0;
    start_under = bus.underrun;
    for (int s = 0; s < FRAME; s++) begin
      for (int j = 0; j < 2 * BCLK_HALF; j++) begin
        if (j == 0) begin
          sd_bits[s] = bus.sdata;
          lr_bits[s] = bus.lrclk;
          if (s == s1) begin bus.in = v1; bus.in_valid = 1'b1; end
          if (s == s2) begin bus.in = v2; bus.in_valid = 1'b1; end
          if (s == FRAME - 1) bus.mute = next_mute;
        end else begin
          bus.in_valid = 1'b0;
          if (bus.frame_start) fs_extra++;
        end
        if (bus.bclk !== ((j >= BCLK_HALF) ? 1'b1 : 1'b0)) bclk_errs++;
        if (bus.overrun) over_cnt++;
        if (ld && s == FRAME - 1 && j == 2 * BCLK_HALF - 1) begin
          bus.in = ldv; bus.in_valid = 1'b1;
        end
        @(negedge clk);
      end
      if (s > 0 && bus.frame_start) fs_extra++;
    end
    if (fs_extra > 0 && bus.frame_start) fs_extra--;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       activity;
    logic [5:0] outs;

    tbl[0] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 0};
    tbl[1] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hA5C3, 1'b1, 0};
    tbl[2] = '{ 5, 16'h0001, 20, 16'h8000, 1'b0, 16'h0000, 1'b0, 16'hA5C3, 1'b1, 1};
    tbl[3] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b0, 0};
    tbl[4] = '{10, 16'h1234, -1, 16'h0000, 1'b1, 16'h5678, 1'b0, 16'h8000, 1'b1, 0};
    tbl[5] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 0};
    tbl[6] = '{40, 16'h7FFF, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h5678, 1'b0, 0};
    tbl[7] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 0};
    tbl[8] = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h7FFF, 1'b1, 0};

    bus.in = '0; bus.in_valid = 1'b0; bus.mute = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_bclk",        bus.bclk,        0);
    check_output("reset_lrclk",       bus.lrclk,       0);
    check_output("reset_sdata",       bus.sdata,       0);
    check_output("reset_frame_start", bus.frame_start, 0);
    check_output("reset_underrun",    bus.underrun,    0);
    check_output("reset_overrun",     bus.overrun,     0);
    reset = 1'b0;

    activity = 1'b0;
    repeat (12) begin
      @(negedge clk);
      activity |= bus.bclk | bus.lrclk | bus.sdata | bus.frame_start;
    end
    check_output("idle_quiet", activity, 0);

    apply_stimulus(16'hA5C3);
    for (int i = 0; i < NVEC; i++) begin
      wait_frame(waited);
      if (i == 0) check_output("startup_latency", waited, 2 * BCLK_HALF);
      else        check_output("frame_period", waited, 0);
      capture_frame(tbl[i].s1, tbl[i].v1, tbl[i].s2, tbl[i].v2, tbl[i].ld, tbl[i].ldv,
                    (i < NVEC - 1) ? tbl[i+1].mute : 1'b0);
      check_output($sformatf("sdata_f%0d", i), sd_bits, expected_frame(tbl[i].exp_word));
      check_output($sformatf("lrclk_f%0d", i), lr_bits, {32'hFFFF_FFFF, 32'h0000_0000});
      check_output($sformatf("underrun_f%0d", i), start_under, tbl[i].exp_under);
      check_output($sformatf("overrun_f%0d", i), over_cnt, tbl[i].exp_over);
      check_output($sformatf("bclk_f%0d", i), bclk_errs, 0);
      check_output($sformatf("frame_start_extra_f%0d", i), fs_extra, 0);
    end

    // Reset in the middle of slot 20 while BCLK is high.
    wait_frame(waited);
    check_output("frame_period_pre_reset", waited, 0);
    repeat (20 * 2 * BCLK_HALF + BCLK_HALF) @(negedge clk);
    check_output("pre_reset_bclk", bus.bclk, 1);
    #1 reset = 1'b1;
    #1;
    outs = {bus.bclk, bus.lrclk, bus.sdata, bus.frame_start, bus.underrun, bus.overrun};
    check_output("async_reset_outputs", outs, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    activity = 1'b0;
    repeat (40) begin
      @(negedge clk);
      activity |= bus.bclk | bus.lrclk | bus.sdata | bus.frame_start;
    end
    check_output("idle_after_reset", activity, 0);

    apply_stimulus(16'h00FF);
    wait_frame(waited);
    check_output("restart_latency", waited, 2 * BCLK_HALF);
    capture_frame(-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check_output("restart_sdata", sd_bits, expected_frame(16'h00FF));
    check_output("restart_underrun", start_under, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
